// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and write-back unit for MiniMIPS32.
// Captures the MEM-stage result each edge, extracts and extends load data
// from the synchronous data-RAM word, and drives the register-file write port.
//
// Optional feature: define MINIMIPS_HILO_EN to add the HI/LO write port
// (mem_whilo/mem_hilo in, wb_whilo/wb_hilo out). Without it, no HI/LO
// ports or state exist.
//
// Ports:
//   cpu_clk_50M  core clock, rising-edge updates
//   cpu_rst      synchronous active-high reset
//   stall        hold WB contents this edge
//   flush        squash the instruction entering WB (wins over stall)
//   mem_*        MEM-stage result fields
//   dm           data-RAM read word, valid in the first WB cycle of a load
//   wb_wa/wb_wd/wb_we        register-file write port
//   wb_whilo/wb_hilo         HI/LO write port (MINIMIPS_HILO_EN only)
module wb_stage #(
  localparam int unsigned REG_BUS      = 32,
  localparam int unsigned REG_ADDR_BUS = 5
) (
  input  logic                    cpu_clk_50M,
  input  logic                    cpu_rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [REG_ADDR_BUS-1:0] mem_wa,
  input  logic                    mem_wreg,
  input  logic [REG_BUS-1:0]      mem_dreg,
  input  logic                    mem_mreg,
  input  logic [3:0]              mem_dre,
  input  logic                    mem_sext,
`ifdef MINIMIPS_HILO_EN
  input  logic                    mem_whilo,
  input  logic [2*REG_BUS-1:0]    mem_hilo,
`endif
  input  logic [REG_BUS-1:0]      dm,
  output logic [REG_ADDR_BUS-1:0] wb_wa,
  output logic [REG_BUS-1:0]      wb_wd,
`ifdef MINIMIPS_HILO_EN
  output logic                    wb_whilo,
  output logic [2*REG_BUS-1:0]    wb_hilo,
`endif
  output logic                    wb_we
);

  logic [REG_ADDR_BUS-1:0] wa_q;
  logic                    wreg_q;
  logic [REG_BUS-1:0]      dreg_q;
  logic                    mreg_q;
  logic [3:0]              dre_q;
  logic                    sext_q;
  logic                    held;
  logic [REG_BUS-1:0]      dm_buf;

  // Pipeline register plus load-word buffer. The buffer freezes the RAM word
  // on the first stalled edge so the RAM is free to change while WB holds.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst || flush) begin
      wa_q   <= '0;
      wreg_q <= 1'b0;
      dreg_q <= '0;
      mreg_q <= 1'b0;
      dre_q  <= '0;
      sext_q <= 1'b0;
      held   <= 1'b0;
      dm_buf <= '0;
    end else if (stall) begin
      if (mreg_q && !held) begin
        held   <= 1'b1;
        dm_buf <= dm;
      end
    end else begin
      wa_q   <= mem_wa;
      wreg_q <= mem_wreg;
      dreg_q <= mem_dreg;
      mreg_q <= mem_mreg;
      dre_q  <= mem_dre;
      sext_q <= mem_sext;
      held   <= 1'b0;
    end
  end

`ifdef MINIMIPS_HILO_EN
  logic                 whilo_q;
  logic [2*REG_BUS-1:0] hilo_q;

  // HI/LO fields follow the same reset/flush/stall rules as the GPR fields.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst || flush) begin
      whilo_q <= 1'b0;
      hilo_q  <= '0;
    end else if (!stall) begin
      whilo_q <= mem_whilo;
      hilo_q  <= mem_hilo;
    end
  end

  assign wb_whilo = whilo_q;
  assign wb_hilo  = hilo_q;
`endif

  function automatic logic [REG_BUS-1:0] ext_byte(input logic [7:0] b, input logic s);
    return s ? {{(REG_BUS-8){b[7]}}, b} : {{(REG_BUS-8){1'b0}}, b};
  endfunction

  function automatic logic [REG_BUS-1:0] ext_half(input logic [15:0] h, input logic s);
    return s ? {{(REG_BUS-16){h[15]}}, h} : {{(REG_BUS-16){1'b0}}, h};
  endfunction

  logic [REG_BUS-1:0] load_word;
  logic [REG_BUS-1:0] load_data;

  // Lane select and extension of the load word.
  always_comb begin
    load_word = held ? dm_buf : dm;
    load_data = '0;
    case (dre_q)
      4'b1111: load_data = load_word;
      4'b0001: load_data = ext_byte(load_word[7:0],   sext_q);
      4'b0010: load_data = ext_byte(load_word[15:8],  sext_q);
      4'b0100: load_data = ext_byte(load_word[23:16], sext_q);
      4'b1000: load_data = ext_byte(load_word[31:24], sext_q);
      4'b0011: load_data = ext_half(load_word[15:0],  sext_q);
      4'b1100: load_data = ext_half(load_word[31:16], sext_q);
      default: load_data = '0;
    endcase
  end

  // Writes to $0 are suppressed.
  assign wb_wa = wa_q;
  assign wb_we = wreg_q && (wa_q != '0);
  assign wb_wd = mreg_q ? load_data : dreg_q;

endmodule
